scoreboard_ctrl: RTL

//  Upstream driver of the scoreboard digit-sprite stage. Holds the player score as a

---
 rtl/scoreboard_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/scoreboard_ctrl.sv
// Scoreboard front end: saturating BCD score, per-frame snapshot, and the
// raster-to-digit-ROM pipeline that feeds the sprite stage.
module scoreboard_ctrl #(
   parameter int DIGITS   = 4,
   parameter int ORIGIN_X = 16,
   parameter int ORIGIN_Y = 8,
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                add_en,
   input  logic [3:0]          add_pts,
   input  logic                frame_start,
   input  logic [9:0]          pixel_x,
   input  logic [9:0]          pixel_y,
   output logic [4*DIGITS-1:0] score_bcd,
   output logic [9:0]          addr,
   output logic                rden,
   output logic [9:0]          onehot,
   output logic                pix_valid
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(SPRITE_W);
   localparam logic [31:0] X_LO = ORIGIN_X;
   localparam logic [31:0] X_HI = ORIGIN_X + DIGITS * SPRITE_W;
   localparam logic [31:0] Y_LO = ORIGIN_Y;
   localparam logic [31:0] Y_HI = ORIGIN_Y + SPRITE_H;

   typedef struct packed {
      logic [9:0] addr;
      logic       rden;
      logic [3:0] val;
   } s1_t;

   typedef struct packed {
      logic [9:0] onehot;
      logic       rden;
   } s2_t;

   logic [SW-1:0] score_q;
   logic [SW-1:0] snap_q;
   logic [SW-1:0] sum_c;
   logic          sat_c;

   s1_t  s1_q;
   s1_t  s1_d;
   s2_t  s2_q;
   s2_t  s2_d;
   logic pv_q;

   // Ripple add: nibble 0 can take up to 9, higher nibbles only a carry of 1.
   always_comb begin
      logic [4:0] acc;
      logic [3:0] carry;
      acc   = '0;
      sum_c = '0;
      carry = (add_pts > 4'd9) ? 4'd9 : add_pts;
      for (int i = 0; i < DIGITS; i++) begin
         acc = {1'b0, score_q[4*i +: 4]} + {1'b0, carry};
         if (acc > 5'd9) begin
            sum_c[4*i +: 4] = 4'(acc - 5'd10);
            carry           = 4'd1;
         end else begin
            sum_c[4*i +: 4] = acc[3:0];
            carry           = 4'd0;
         end
      end
      sat_c = (carry != 4'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= '0;
      end else if (clr) begin
         score_q <= '0;
      end else if (add_en) begin
         score_q <= sat_c ? {DIGITS{4'h9}} : sum_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q <= '0;
      end else if (frame_start) begin
         snap_q <= score_q;
      end
   end

   logic          in_x;
   logic          in_y;
   logic [9:0]    dx;
   logic [9:0]    dy;
   logic [9:0]    pos;
   logic [DIGITS-1:0] lz;
   logic [3:0]    val_c;
   logic          blank_c;

   assign in_x = (32'(pixel_x) >= X_LO) && (32'(pixel_x) < X_HI);
   assign in_y = (32'(pixel_y) >= Y_LO) && (32'(pixel_y) < Y_HI);
   assign dx   = pixel_x - 10'(ORIGIN_X);
   assign dy   = pixel_y - 10'(ORIGIN_Y);
   assign pos  = dx >> CW;

   // lz[p]: positions 0..p (MSD side) of the snapshot are all zero.
   always_comb begin
      logic zrun;
      zrun = 1'b1;
      lz   = '0;
      for (int p = 0; p < DIGITS; p++) begin
         zrun  = zrun & (snap_q[4*(DIGITS-1-p) +: 4] == 4'd0);
         lz[p] = zrun;
      end
   end

   always_comb begin
      val_c   = '0;
      blank_c = 1'b0;
      for (int p = 0; p < DIGITS; p++) begin
         if (pos == 10'(p)) begin
            val_c   = snap_q[4*(DIGITS-1-p) +: 4];
            blank_c = lz[p] && (p != DIGITS - 1);
         end
      end
   end

   always_comb begin
      s1_d      = '0;
      s1_d.rden = in_x & in_y & ~blank_c;
      s1_d.val  = val_c;
      if (s1_d.rden) begin
         s1_d.addr = 10'((32'(dy) << CW) | 32'(dx[CW-1:0]));
      end
   end

   always_comb begin
      s2_d      = '0;
      s2_d.rden = s1_q.rden;
      if (s1_q.rden) begin
         s2_d.onehot = 10'd1 << s1_q.val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         pv_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         pv_q <= s2_q.rden;
      end
   end

   assign score_bcd = score_q;
   assign addr      = s1_q.addr;
   assign rden      = s1_q.rden;
   assign onehot    = s2_q.onehot;
   assign pix_valid = pv_q;

endmodule
